mem_wb_load_stage: RTL and testbench
====================================

Name: mem_wb_load_stage

Overview:
- Pipeline register between the memory stage (data-memory block RAM plus address/BE logic) and the register-file write-back stage of the 5-stage MIPS core.
- Captures the data-memory read word in the same cycle it is valid. Aligns and sign/zero-extends it per load type.
- Muxes the load result against the ALU result and presents a registered write-back bundle (pc, destination, data, write enable).
- Handles stall (hold), flush (bubble) and exception suppression of the register write.

Parameters:
- RESET_PC, 32'h0000_3000, value loaded into w_pc on reset and on flush.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall_w  in  1  hold all W registers this cycle.
- flush_w  in  1  load a bubble this cycle.
- m_valid  in  1  M-stage slot holds a real instruction.
- m_pc  in  32  M-stage instruction address.
- m_regWrite  in  1  instruction writes the register file.
- m_wreg  in  5  destination register number.
- m_aluResult  in  32  ALU / address result carried from E.
- m_memToReg  in  1  write-back source: 1 = load data, 0 = m_aluResult.
- m_loadType  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; others treated as lw.
- m_addrLow  in  2  effective address bits [1:0].
- m_exc  in  1  M-stage exception; the instruction must not commit a register write.
- dm_rdata  in  32  word read from data memory for the M-stage address; valid before the clk rising edge of the same cycle.
- w_valid  out  1  W slot holds a real instruction.
- w_pc  out  32  W-stage pc (for the debug/trace interface).
- w_regWrite  out  1  register-file write enable.
- w_wreg  out  5  register-file write address.
- w_wdata  out  32  register-file write data.
- w_isLoad  out  1  W instruction is a load; feeds forwarding and hazard logic.

Behaviour:
- Reset (reset=0, asynchronous): w_valid=0, w_pc=RESET_PC, w_regWrite=0, w_wreg=0, w_wdata=0, w_isLoad=0. Outputs hold these values until the first rising edge after reset deasserts.
- Priority at each rising edge: reset > flush_w > stall_w > normal load.
- flush_w=1: same values as reset. This applies even when stall_w=1.
- stall_w=1 with flush_w=0: every W register holds its value. dm_rdata is ignored.
- Normal load latency: one cycle. The inputs sampled at edge N appear on the outputs after edge N.
- Byte select: byte k = dm_rdata[8k+7:8k], with k=m_addrLow.
  - lb sign-extends byte k.
  - lbu zero-extends byte k.
- Halfword select: m_addrLow[1] picks the upper (1) or lower (0) half; m_addrLow[0] is ignored (misalignment is trapped upstream).
  - lh sign-extends the selected half.
  - lhu zero-extends the selected half.
- lw and reserved m_loadType codes pass dm_rdata unchanged.
- w_wdata = extended load data if m_memToReg=1, else m_aluResult.
- w_regWrite = m_valid & m_regWrite & ~m_exc & (m_wreg != 0).
- w_wreg = m_wreg; w_isLoad = m_valid & m_memToReg; w_valid = m_valid.
- When m_valid=0: w_regWrite=0 and w_isLoad=0. Data fields still load but are don't-care.
- The block is purely registered: there is no combinational path from any input to any output.
- Reset asserted mid-stall: outputs go to reset values at once. The first edge after release loads normally unless stall or flush is asserted.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs -> all outputs 0 except w_pc=32'h0000_3000. Release, drive an lw with dm_rdata=32'hDEADBEEF, wreg=8 -> after one edge w_wdata=32'hDEADBEEF, w_regWrite=1, w_wreg=8, w_isLoad=1.
- Byte loads: dm_rdata=32'h80F17F01.
  - lb at addrLow=0..3 -> 32'h00000001, 32'h0000007F, 32'hFFFFFFF1, 32'hFFFFFF80.
  - lbu at addrLow=3 -> 32'h00000080.
- Half loads: dm_rdata=32'h8001_7FFE.
  - lh addrLow=0 -> 32'h00007FFE.
  - lh addrLow=2 -> 32'hFFFF8001.
  - lhu addrLow=2 -> 32'h00008001.
- Non-load: m_memToReg=0, m_aluResult=32'h12345678, dm_rdata=32'hFFFFFFFF -> w_wdata=32'h12345678, w_isLoad=0.
- Write suppression: m_wreg=0, then m_exc=1, then m_valid=0, each with m_regWrite=1 -> w_regWrite=0 in all three cases.
- Stall/flush:
  - Load an add to $9 with value 5, then assert stall_w for 2 cycles while the inputs change -> outputs keep $9/5.
  - Assert stall_w and flush_w together -> bubble: w_valid=0, w_regWrite=0, w_pc=RESET_PC.

Source files
------------

// File: rtl/mem_wb_load_stage.sv
// Purpose : M->W pipeline register; aligns and extends load data and muxes it against the ALU result.
// Latency : one cycle; inputs sampled at edge N appear on the outputs after edge N.
// Backpr. : stall_w holds every W register, flush_w (wins over stall_w) loads a bubble.
//
// Ports:
//   clk, reset (async, active-low), stall_w, flush_w
//   m_*       : M-stage instruction bundle (valid, pc, regWrite, wreg, aluResult,
//               memToReg, loadType, addrLow, exc)
//   dm_rdata  : data-memory read word for the M-stage address, valid this cycle
//   w_*       : registered write-back bundle (valid, pc, regWrite, wreg, wdata, isLoad)
module mem_wb_load_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_w,
  input  logic        flush_w,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_regWrite,
  input  logic [4:0]  m_wreg,
  input  logic [31:0] m_aluResult,
  input  logic        m_memToReg,
  input  logic [2:0]  m_loadType,
  input  logic [1:0]  m_addrLow,
  input  logic        m_exc,
  input  logic [31:0] dm_rdata,
  output logic        w_valid,
  output logic [31:0] w_pc,
  output logic        w_regWrite,
  output logic [4:0]  w_wreg,
  output logic [31:0] w_wdata,
  output logic        w_isLoad
);

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] wdata_nxt;
  logic        regwrite_nxt;

  // Lane extraction. Half select only looks at addrLow[1]; a misaligned
  // halfword never reaches this stage because it traps upstream.
  always_comb begin
    byte_sel = 8'h00;
    case (m_addrLow)
      2'd0:    byte_sel = dm_rdata[7:0];
      2'd1:    byte_sel = dm_rdata[15:8];
      2'd2:    byte_sel = dm_rdata[23:16];
      default: byte_sel = dm_rdata[31:24];
    endcase
    half_sel = m_addrLow[1] ? dm_rdata[31:16] : dm_rdata[15:0];
  end

  // Reserved load-type codes behave as lw.
  always_comb begin
    load_data = dm_rdata;
    case (m_loadType)
      LT_LW:   load_data = dm_rdata;
      LT_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  load_data = {24'h000000, byte_sel};
      LT_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  load_data = {16'h0000, half_sel};
      default: load_data = dm_rdata;
    endcase
  end

  assign wdata_nxt = m_memToReg ? load_data : m_aluResult;

  // $0 is hardwired; an excepting or empty slot must never commit.
  assign regwrite_nxt = m_valid & m_regWrite & ~m_exc & (m_wreg != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_valid    <= 1'b0;
      w_pc       <= RESET_PC;
      w_regWrite <= 1'b0;
      w_wreg     <= 5'd0;
      w_wdata    <= 32'h0;
      w_isLoad   <= 1'b0;
    end else if (flush_w) begin
      w_valid    <= 1'b0;
      w_pc       <= RESET_PC;
      w_regWrite <= 1'b0;
      w_wreg     <= 5'd0;
      w_wdata    <= 32'h0;
      w_isLoad   <= 1'b0;
    end else if (!stall_w) begin
      w_valid    <= m_valid;
      w_pc       <= m_pc;
      w_regWrite <= regwrite_nxt;
      w_wreg     <= m_wreg;
      w_wdata    <= wdata_nxt;
      w_isLoad   <= m_valid & m_memToReg;
    end
  end

endmodule

// File: tb/tb_mem_wb_load_stage.sv
module tb_mem_wb_load_stage;

  localparam logic [31:0] RPC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_w, flush_w;
  logic        m_valid, m_regWrite, m_memToReg, m_exc;
  logic [31:0] m_pc, m_aluResult, dm_rdata;
  logic [4:0]  m_wreg;
  logic [2:0]  m_loadType;
  logic [1:0]  m_addrLow;
  logic        w_valid, w_regWrite, w_isLoad;
  logic [31:0] w_pc, w_wdata;
  logic [4:0]  w_wreg;

  int total  = 0;
  int passed = 0;

  mem_wb_load_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall_w(stall_w), .flush_w(flush_w),
    .m_valid(m_valid), .m_pc(m_pc), .m_regWrite(m_regWrite), .m_wreg(m_wreg),
    .m_aluResult(m_aluResult), .m_memToReg(m_memToReg), .m_loadType(m_loadType),
    .m_addrLow(m_addrLow), .m_exc(m_exc), .dm_rdata(dm_rdata),
    .w_valid(w_valid), .w_pc(w_pc), .w_regWrite(w_regWrite), .w_wreg(w_wreg),
    .w_wdata(w_wdata), .w_isLoad(w_isLoad)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rw,
                       input logic [4:0] wr, input logic [31:0] alu, input logic m2r,
                       input logic [2:0] lt, input logic [1:0] al, input logic exc,
                       input logic [31:0] rd);
    m_valid = v; m_pc = pc; m_regWrite = rw; m_wreg = wr; m_aluResult = alu;
    m_memToReg = m2r; m_loadType = lt; m_addrLow = al; m_exc = exc; dm_rdata = rd;
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".valid"},    {31'h0, w_valid},    32'h0);
    chk({tag, ".pc"},       w_pc,                RPC);
    chk({tag, ".regWrite"}, {31'h0, w_regWrite}, 32'h0);
    chk({tag, ".wreg"},     {27'h0, w_wreg},     32'h0);
    chk({tag, ".wdata"},    w_wdata,             32'h0);
    chk({tag, ".isLoad"},   {31'h0, w_isLoad},   32'h0);
  endtask

  // Load-type probe: lw-style slot writing $3, result compared to exp.
  task automatic load_chk(input string tag, input logic [2:0] lt, input logic [1:0] al,
                          input logic [31:0] rd, input logic [31:0] exp);
    drive(1'b1, 32'h0000_0200, 1'b1, 5'd3, 32'hCAFE_0000, 1'b1, lt, al, 1'b0, rd);
    step();
    chk(tag, w_wdata, exp);
  endtask

  initial begin
    // Reset with random inputs for 3 cycles.
    reset = 1'b0; stall_w = 1'b0; flush_w = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom);
      step();
    end
    chk_reset_vals("reset");

    // First load after release.
    reset = 1'b1;
    drive(1'b1, 32'h0000_0100, 1'b1, 5'd8, 32'h0, 1'b1, 3'b000, 2'd0, 1'b0, 32'hDEADBEEF);
    step();
    chk("lw.wdata",    w_wdata,             32'hDEADBEEF);
    chk("lw.regWrite", {31'h0, w_regWrite}, 32'h1);
    chk("lw.wreg",     {27'h0, w_wreg},     32'd8);
    chk("lw.isLoad",   {31'h0, w_isLoad},   32'h1);
    chk("lw.valid",    {31'h0, w_valid},    32'h1);
    chk("lw.pc",       w_pc,                32'h0000_0100);

    // Byte loads.
    load_chk("lb0",  3'b001, 2'd0, 32'h80F17F01, 32'h00000001);
    load_chk("lb1",  3'b001, 2'd1, 32'h80F17F01, 32'h0000007F);
    load_chk("lb2",  3'b001, 2'd2, 32'h80F17F01, 32'hFFFFFFF1);
    load_chk("lb3",  3'b001, 2'd3, 32'h80F17F01, 32'hFFFFFF80);
    load_chk("lbu3", 3'b010, 2'd3, 32'h80F17F01, 32'h00000080);
    load_chk("lbu2", 3'b010, 2'd2, 32'h80F17F01, 32'h000000F1);

    // Half loads; addrLow[0] is ignored.
    load_chk("lh0",  3'b011, 2'd0, 32'h80017FFE, 32'h00007FFE);
    load_chk("lh2",  3'b011, 2'd2, 32'h80017FFE, 32'hFFFF8001);
    load_chk("lhu2", 3'b100, 2'd2, 32'h80017FFE, 32'h00008001);
    load_chk("lh3",  3'b011, 2'd3, 32'h80017FFE, 32'hFFFF8001);
    load_chk("lhu0", 3'b100, 2'd0, 32'h80017FFE, 32'h00007FFE);

    // Reserved load type behaves as lw.
    load_chk("lt7",  3'b111, 2'd1, 32'h80017FFE, 32'h80017FFE);

    // Non-load selects the ALU result.
    drive(1'b1, 32'h0000_0300, 1'b1, 5'd4, 32'h12345678, 1'b0, 3'b001, 2'd0, 1'b0, 32'hFFFFFFFF);
    step();
    chk("alu.wdata",  w_wdata,           32'h12345678);
    chk("alu.isLoad", {31'h0, w_isLoad}, 32'h0);

    // Write suppression.
    drive(1'b1, 32'h0000_0304, 1'b1, 5'd0, 32'h1, 1'b0, 3'b000, 2'd0, 1'b0, 32'h0);
    step();
    chk("sup.wreg0", {31'h0, w_regWrite}, 32'h0);
    drive(1'b1, 32'h0000_0308, 1'b1, 5'd5, 32'h1, 1'b0, 3'b000, 2'd0, 1'b1, 32'h0);
    step();
    chk("sup.exc", {31'h0, w_regWrite}, 32'h0);
    drive(1'b0, 32'h0000_030C, 1'b1, 5'd5, 32'h1, 1'b1, 3'b000, 2'd0, 1'b0, 32'h0);
    step();
    chk("sup.invalid.rw", {31'h0, w_regWrite}, 32'h0);
    chk("sup.invalid.ld", {31'h0, w_isLoad},   32'h0);
    chk("sup.invalid.v",  {31'h0, w_valid},    32'h0);

    // Stall holds an add to $9 = 5.
    drive(1'b1, 32'h0000_0400, 1'b1, 5'd9, 32'd5, 1'b0, 3'b000, 2'd0, 1'b0, 32'h0);
    step();
    chk("add.wdata", w_wdata, 32'd5);
    stall_w = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h0000_0500 + 32'(i), 1'b1, 5'd12, 32'h77, 1'b1, 3'b000, 2'd0, 1'b0, 32'hAAAA5555);
      step();
      chk("stall.wreg",  {27'h0, w_wreg},   32'd9);
      chk("stall.wdata", w_wdata,           32'd5);
      chk("stall.pc",    w_pc,              32'h0000_0400);
      chk("stall.ld",    {31'h0, w_isLoad}, 32'h0);
    end

    // Flush beats stall.
    flush_w = 1'b1;
    step();
    chk_reset_vals("flush");

    // Reset asserted mid-stall takes effect without a clock edge.
    flush_w = 1'b0; stall_w = 1'b0;
    drive(1'b1, 32'h0000_0600, 1'b1, 5'd7, 32'h0, 1'b1, 3'b000, 2'd0, 1'b0, 32'h0BADF00D);
    step();
    chk("pre.wdata", w_wdata, 32'h0BADF00D);
    stall_w = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_vals("arst");
    @(negedge clk);
    reset = 1'b1; stall_w = 1'b0;
    drive(1'b1, 32'h0000_0700, 1'b1, 5'd6, 32'h0, 1'b1, 3'b010, 2'd1, 1'b0, 32'h0000C300);
    step();
    chk("post.wdata", w_wdata,         32'h000000C3);
    chk("post.wreg",  {27'h0, w_wreg}, 32'd6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
